// File: rtl/risc_mem_pkg.sv
// Shared types and defaults for the data-memory store buffer.
// The store-forwarding option is selected by the STORE_FWD_EN macro.
package risc_mem_pkg;

    localparam int SB_DEPTH   = 4;
    localparam int SB_AW      = 32;
    localparam int SB_DW      = 32;
    localparam int SB_ENTRY_W = SB_AW + SB_DW;
    localparam int SB_PTR_W   = $clog2(SB_DEPTH);

    typedef logic [1:0] sb_state_t;

    localparam sb_state_t ST_IDLE    = 2'd0;
    localparam sb_state_t ST_WR      = 2'd1;
    localparam sb_state_t ST_RD      = 2'd2;
    localparam sb_state_t ST_RD_DONE = 2'd3;

endpackage

// File: rtl/dmem_store_buffer_store_fifo.sv
// Store FIFO: entry storage, wrapping pointers, occupancy count and,
// when STORE_FWD_EN is defined, a youngest-match address lookup.
module store_fifo
    import risc_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty
`ifdef STORE_FWD_EN
    ,
    input  logic [AW-1:0] lookup_addr,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = AW + DW;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] entry_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    // Entry storage, written at the tail on push
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= {ENTRY_W{1'b0}};
            end
        end else if (push) begin
            entry_r[wr_ptr_r] <= {push_addr, push_data};
        end
    end

    // Pointers wrap naturally at DEPTH; a simultaneous push and pop leaves the count alone
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_addr = entry_r[rd_ptr_r][ENTRY_W-1:DW];
    assign head_data = entry_r[rd_ptr_r][DW-1:0];
    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {CNT_W{1'b0}});

`ifdef STORE_FWD_EN
    logic [DEPTH-1:0] age_match_s;

    // Bit k flags the k-th oldest valid entry whose address matches the load
    always_comb begin
        age_match_s = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            age_match_s[k] = (CNT_W'(k) < count_r) &&
                             (entry_r[rd_ptr_r + PTR_W'(k)][ENTRY_W-1:DW] == lookup_addr);
        end
    end

    // Scanning oldest to youngest lets the youngest match overwrite older ones
    always_comb begin
        fwd_hit  = |age_match_s;
        fwd_data = {DW{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            fwd_data = age_match_s[k] ? entry_r[rd_ptr_r + PTR_W'(k)][DW-1:0] : fwd_data;
        end
    end
`endif

endmodule

// File: rtl/dmem_store_buffer.sv
// MEM-stage data-memory front end: posts stores into a FIFO, drains them to
// a req/ack bus and services loads. Define STORE_FWD_EN for store-to-load forwarding.
module dmem_store_buffer
    import risc_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    input  logic          core_we,
    input  logic          core_re,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    output logic          buf_empty,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    sb_state_t     state_r;
    sb_state_t     state_nxt_s;
    logic          load_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;
    logic          fwd_hit_s;
    logic          load_go_s;
    logic [AW-1:0] head_addr_s;
    logic [DW-1:0] head_data_s;

    logic          mem_req_r;
    logic          mem_we_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic [DW-1:0] rdata_r;
    logic          mem_req_nxt_s;
    logic          mem_we_nxt_s;
    logic [AW-1:0] mem_addr_nxt_s;
    logic [DW-1:0] mem_wdata_nxt_s;
    logic [DW-1:0] rdata_nxt_s;

    // A simultaneous store and load is handled as the store alone
    assign load_s = core_re & ~core_we;
    assign push_s = core_we & ~full_s;
    assign pop_s  = (state_r == ST_WR) & mem_ack;

`ifdef STORE_FWD_EN
    logic          cam_hit_s;
    logic [DW-1:0] fwd_data_s;

    store_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk         (clk),
        .clr         (clr),
        .push        (push_s),
        .push_addr   (core_addr),
        .push_data   (core_wdata),
        .pop         (pop_s),
        .head_addr   (head_addr_s),
        .head_data   (head_data_s),
        .full        (full_s),
        .empty       (empty_s),
        .lookup_addr (core_addr),
        .fwd_hit     (cam_hit_s),
        .fwd_data    (fwd_data_s)
    );

    // Missing loads overtake queued stores; hits never touch the bus
    assign fwd_hit_s  = load_s & cam_hit_s;
    assign load_go_s  = load_s & ~cam_hit_s;
    assign core_rdata = fwd_hit_s ? fwd_data_s : rdata_r;
`else
    store_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .push      (push_s),
        .push_addr (core_addr),
        .push_data (core_wdata),
        .pop       (pop_s),
        .head_addr (head_addr_s),
        .head_data (head_data_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign fwd_hit_s  = 1'b0;
    assign load_go_s  = load_s & empty_s;
    assign core_rdata = rdata_r;
`endif

    assign buf_empty  = empty_s;
    assign core_stall = (core_we & full_s) |
                        (load_s & ~((state_r == ST_RD_DONE) | fwd_hit_s));

    // FSM state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: an eligible load wins over draining
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_go_s) begin
                    state_nxt_s = ST_RD;
                end else if (!empty_s) begin
                    state_nxt_s = ST_WR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR: begin
                if (mem_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WR;
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    state_nxt_s = ST_RD_DONE;
                end else begin
                    state_nxt_s = ST_RD;
                end
            end
            ST_RD_DONE: state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they register alongside it
    always_comb begin
        mem_req_nxt_s   = 1'b0;
        mem_we_nxt_s    = 1'b0;
        mem_addr_nxt_s  = mem_addr_r;
        mem_wdata_nxt_s = mem_wdata_r;
        case (state_nxt_s)
            ST_WR: begin
                mem_req_nxt_s   = 1'b1;
                mem_we_nxt_s    = 1'b1;
                mem_addr_nxt_s  = head_addr_s;
                mem_wdata_nxt_s = head_data_s;
            end
            ST_RD: begin
                mem_req_nxt_s  = 1'b1;
                mem_addr_nxt_s = core_addr;
            end
            default: begin
                mem_req_nxt_s = 1'b0;
                mem_we_nxt_s  = 1'b0;
            end
        endcase
        if ((state_r == ST_RD) && mem_ack) begin
            rdata_nxt_s = mem_rdata;
        end else begin
            rdata_nxt_s = rdata_r;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            rdata_r     <= {DW{1'b0}};
        end else begin
            mem_req_r   <= mem_req_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
            rdata_r     <= rdata_nxt_s;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule
